// File: rtl/udp_rx_demux.sv
`timescale 1ns/1ps
`default_nettype none
// udp_rx_demux: Ethernet/IPv4/UDP receive parser that steers UDP payload to one of NUM_PORTS channels.
// Optional CRC-32 FCS check is enabled with `define UDP_RX_FCS_CHECK_EN. Rev 1.0
module udp_rx_demux #(
  parameter logic [47:0]             FPGA_MAC         = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0]             FPGA_IP          = 32'hC0_00_02_92,
  parameter int                      NUM_PORTS        = 4,
  parameter logic [NUM_PORTS*16-1:0] PORT_LIST        = {16'd5008, 16'd5007, 16'd5006, 16'd5005},
  parameter bit                      ACCEPT_BROADCAST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  received_byte,
  input  logic        byte_valid,
  input  logic        rx_active,
  output logic [7:0]  payload,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        payload_abort,
  output logic [2:0]  payload_chan,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ETH, S_IP, S_UDP, S_PAY, S_DONE, S_REJ, S_SKIP
  } state_t;

  state_t      state, state_n;
  logic [5:0]  cnt;
  logic [47:0] mac;
  logic [7:0]  etype_hi;
  logic [3:0]  ihl;
  logic [7:0]  proto;
  logic [31:0] dip;
  logic [7:0]  sum_hi;
  logic [19:0] sum;
  logic [15:0] dport, ulen, rem;
  logic [2:0]  chan_hit;
  logic        port_hit;
  logic        pv_n, last_n, abort_n, good_n, bad_n;

  logic [47:0] mac_full;
  logic        mac_ok, mac_known;
  logic [31:0] dip_full;
  logic [19:0] sum_full, fold1;
  logic [15:0] fold2;
  logic        csum_ok;
  logic [5:0]  hdr_last;
  logic        fcs_ok;

  // The sixth MAC byte may be arriving this cycle; decide on it without waiting.
  assign mac_full  = (cnt == 6'd5 && byte_valid) ? {mac[39:0], received_byte} : mac;
  assign mac_ok    = (mac_full == FPGA_MAC) || (ACCEPT_BROADCAST && (mac_full == {48{1'b1}}));
  assign mac_known = (state == S_ETH) && ((cnt > 6'd5) || (cnt == 6'd5 && byte_valid));
  assign dip_full  = (cnt == 6'd19) ? {dip[23:0], received_byte} : dip;
  assign sum_full  = sum + {4'h0, sum_hi, received_byte};
  assign fold1     = {4'h0, sum_full[15:0]} + {16'h0, sum_full[19:16]};
  assign fold2     = fold1[15:0] + {12'h0, fold1[19:16]};
  assign csum_ok   = (fold2 == 16'hFFFF);
  assign hdr_last  = {ihl, 2'b00} - 6'd1;

  always_comb begin
    port_hit = 1'b0;
    chan_hit = 3'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (PORT_LIST[16*i +: 16] == dport) begin
        port_hit = 1'b1;
        chan_hit = 3'(i);
      end
    end
  end

`ifdef UDP_RX_FCS_CHECK_EN
  logic [31:0] crc, crc_cur;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign crc_cur = byte_valid ? crc_step(crc, received_byte) : crc;
  assign fcs_ok  = (crc_cur == 32'hDEBB_20E3);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         crc <= '1;
    else if (byte_valid) crc <= (state == S_IDLE) ? '1 : crc_cur;
  end
`else
  assign fcs_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Byte handling first, then end-of-frame is judged on the post-byte state.
  always_comb begin
    state_n = state;
    pv_n    = 1'b0;
    last_n  = 1'b0;
    abort_n = 1'b0;
    good_n  = 1'b0;
    bad_n   = 1'b0;
    if (byte_valid) begin
      case (state)
        S_IDLE: if (received_byte == 8'hD5) state_n = S_ETH;
        S_ETH: if (cnt == 6'd13) begin
          if (!mac_ok)                                      state_n = S_SKIP;
          else if ({etype_hi, received_byte} == 16'h0800)   state_n = S_IP;
          else                                              state_n = S_REJ;
        end
        S_IP: if (cnt == 6'd0) begin
          if (received_byte[7:4] != 4'd4 || received_byte[3:0] < 4'd5) state_n = S_REJ;
        end else if (cnt == hdr_last) begin
          if (csum_ok && proto == 8'd17 && dip_full == FPGA_IP) state_n = S_UDP;
          else                                                  state_n = S_REJ;
        end
        S_UDP: if (cnt == 6'd7) begin
          if (!port_hit || ulen < 16'd8) state_n = S_REJ;
          else if (ulen == 16'd8)        state_n = S_DONE;
          else                           state_n = S_PAY;
        end
        S_PAY: begin
          pv_n = 1'b1;
          if (rem == 16'd1) begin
            last_n  = 1'b1;
            state_n = S_DONE;
          end
        end
        default: ;
      endcase
    end
    if (!rx_active) begin
      case (state_n)
        S_IDLE: ;
        S_ETH: begin
          bad_n   = mac_known && mac_ok;
          state_n = S_IDLE;
        end
        S_PAY: begin
          abort_n = 1'b1;
          bad_n   = 1'b1;
          state_n = S_IDLE;
        end
        S_DONE: begin
          good_n  = fcs_ok;
          bad_n   = !fcs_ok;
          state_n = S_IDLE;
        end
        S_SKIP:  state_n = S_IDLE;
        default: begin
          bad_n   = 1'b1;
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0; mac <= '0; etype_hi <= '0; ihl <= '0; proto <= '0; dip <= '0;
      sum_hi <= '0; sum <= '0; dport <= '0; ulen <= '0; rem <= '0;
      payload <= '0; payload_valid <= 1'b0; payload_last <= 1'b0; payload_abort <= 1'b0;
      payload_chan <= '0; frame_good <= 1'b0; frame_bad <= 1'b0; drop_count <= '0;
    end else begin
      payload       <= pv_n ? received_byte : 8'h00;
      payload_valid <= pv_n;
      payload_last  <= last_n;
      payload_abort <= abort_n;
      frame_good    <= good_n;
      frame_bad     <= bad_n;
      if (bad_n && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;

      if (state_n != state) cnt <= '0;
      else if (byte_valid)  cnt <= cnt + 6'd1;

      if (state == S_IDLE) sum <= '0;

      if (byte_valid) begin
        case (state)
          S_ETH: begin
            if (cnt < 6'd6)   mac <= {mac[39:0], received_byte};
            if (cnt == 6'd12) etype_hi <= received_byte;
          end
          S_IP: begin
            if (cnt == 6'd0)                   ihl <= received_byte[3:0];
            if (cnt == 6'd9)                   proto <= received_byte;
            if (cnt >= 6'd16 && cnt <= 6'd19)  dip <= {dip[23:0], received_byte};
            if (!cnt[0]) sum_hi <= received_byte;
            else         sum    <= sum_full;
          end
          S_UDP: begin
            if (cnt == 6'd2 || cnt == 6'd3) dport <= {dport[7:0], received_byte};
            if (cnt == 6'd4 || cnt == 6'd5) ulen  <= {ulen[7:0], received_byte};
            if (cnt == 6'd7) begin
              payload_chan <= chan_hit;
              rem          <= ulen - 16'd8;
            end
          end
          S_PAY:   rem <= rem - 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_demux.sv
`timescale 1ns/1ps
`default_nettype none
// tb_udp_rx_demux: randomized frames against a frame-level reference model, scoreboard-checked.
module tb_udp_rx_demux;
  localparam logic [47:0] MAC = 48'h00_1A_2B_3C_4D_5E;
  localparam logic [31:0] IP  = 32'hC0_00_02_92;
  localparam int K_PAY = 0, K_ABORT = 1, K_GOOD = 2, K_BAD = 3;

  typedef logic [7:0] u8;
  typedef struct { int kind; int data; int chan; int last; int drop; } ev_t;

  logic clk = 1'b0, resetn = 1'b0, byte_valid = 1'b0, rx_active = 1'b0;
  logic [7:0] received_byte = 8'h00;

  logic [7:0] a_payload, b_payload;
  logic a_pv, a_pl, a_pa, a_fg, a_fb, b_pv, b_pl, b_pa, b_fg, b_fb;
  logic [2:0] a_pc, b_pc;
  logic [15:0] a_dc, b_dc;

  udp_rx_demux dut_a (
    .clk(clk), .resetn(resetn), .received_byte(received_byte), .byte_valid(byte_valid),
    .rx_active(rx_active), .payload(a_payload), .payload_valid(a_pv), .payload_last(a_pl),
    .payload_abort(a_pa), .payload_chan(a_pc), .frame_good(a_fg), .frame_bad(a_fb),
    .drop_count(a_dc));

  udp_rx_demux #(.ACCEPT_BROADCAST(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .received_byte(received_byte), .byte_valid(byte_valid),
    .rx_active(rx_active), .payload(b_payload), .payload_valid(b_pv), .payload_last(b_pl),
    .payload_abort(b_pa), .payload_chan(b_pc), .frame_good(b_fg), .frame_bad(b_fb),
    .drop_count(b_dc));

  always #10 clk = ~clk;

  ev_t qa[$], qb[$];
  u8   fr[$];
  int  checks = 0, errors = 0;
  int  drop_a = 0, drop_b = 0;
  bit  fcs_bad = 1'b0;
  int  ports[4] = '{5005, 5006, 5007, 5008};

  task automatic check(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic bit pop(int d, output ev_t e);
    e = '{default: 0};
    if (d == 0) begin
      if (qa.size() == 0) return 1'b0;
      e = qa.pop_front();
    end else begin
      if (qb.size() == 0) return 1'b0;
      e = qb.pop_front();
    end
    return 1'b1;
  endfunction

  task automatic push(int d, int kind, int data, int chan, int last, int drop);
    ev_t e;
    e = '{kind, data, chan, last, drop};
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic expect_ev(int d, int kind, int data, int chan, int last, int drop);
    ev_t e;
    checks++;
    if (!pop(d, e)) begin
      errors++;
      $display("FAIL d%0d_event act=kind%0d exp=none", d, kind);
      return;
    end
    if (e.kind != kind) begin
      errors++;
      $display("FAIL d%0d_event_kind act=%0d exp=%0d", d, kind, e.kind);
      return;
    end
    if (kind == K_PAY) begin
      check($sformatf("d%0d_pay_data", d), data, e.data);
      check($sformatf("d%0d_pay_chan", d), chan, e.chan);
      check($sformatf("d%0d_pay_last", d), last, e.last);
    end else if (kind != K_ABORT) begin
      check($sformatf("d%0d_drop_at_end", d), drop, e.drop);
    end
  endtask

  task automatic mon(int d, logic [7:0] p, logic pv, logic pl, logic pa, logic [2:0] pc,
                     logic fg, logic fb, logic [15:0] dc);
    if (pl && !pv) check($sformatf("d%0d_last_wo_valid", d), pv, 1);
    if (pv) expect_ev(d, K_PAY, p, pc, pl, 0);
    if (pa) expect_ev(d, K_ABORT, 0, 0, 0, 0);
    if (fg) expect_ev(d, K_GOOD, 0, 0, 0, dc);
    if (fb) expect_ev(d, K_BAD, 0, 0, 0, dc);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      mon(0, a_payload, a_pv, a_pl, a_pa, a_pc, a_fg, a_fb, a_dc);
      mon(1, b_payload, b_pv, b_pl, b_pa, b_pc, b_fg, b_fb, b_dc);
    end
  end

  // Reference model: decides the frame outcome from its fields, given n bytes seen before rx_active fell.
  task automatic model(int d, int n, bit noend);
    logic [47:0] m;
    longint s;
    int drop, hlen, u, ulen, dport, pi, L, k;
    bit bad, done, abort;
    drop = (d == 0) ? drop_a : drop_b;
    bad = 0; done = 0; abort = 0;
    m = '0;
    for (int i = 0; i < 6; i++) m = {m[39:0], fr[i]};
    if (!(m == MAC || (d == 0 && m == '1))) return;
    if (n < 6) return;
    if (n < 14 || {fr[12], fr[13]} != 16'h0800) bad = 1;
    else if (fr[14][7:4] != 4'd4 || fr[14][3:0] < 4'd5) bad = 1;
    else begin
      hlen = int'(fr[14][3:0]) * 4;
      if (n < 14 + hlen) bad = 1;
      else begin
        s = 0;
        for (int i = 0; i < hlen; i += 2) s += {fr[14+i], fr[15+i]};
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        if (s != 64'hFFFF || fr[23] != 8'd17 || {fr[30], fr[31], fr[32], fr[33]} != IP) bad = 1;
        else begin
          u = 14 + hlen;
          if (n < u + 8) bad = 1;
          else begin
            dport = {fr[u+2], fr[u+3]};
            ulen  = {fr[u+4], fr[u+5]};
            pi = -1;
            for (int i = 3; i >= 0; i--) if (ports[i] == dport) pi = i;
            if (pi < 0 || ulen < 8) bad = 1;
            else begin
              L = ulen - 8;
              k = (L < n - u - 8) ? L : n - u - 8;
              for (int i = 0; i < k; i++) push(d, K_PAY, fr[u+8+i], pi, (i == L - 1), 0);
              if (k < L) begin abort = 1; bad = 1; end
              else done = 1;
            end
          end
        end
      end
    end
    if (noend) return;
`ifdef UDP_RX_FCS_CHECK_EN
    if (done && (n != fr.size() || fcs_bad)) begin done = 0; bad = 1; end
`endif
    if (abort) push(d, K_ABORT, 0, 0, 0, 0);
    if (bad) begin
      if (drop < 65535) drop++;
      push(d, K_BAD, 0, 0, 0, drop);
    end else if (done) push(d, K_GOOD, 0, 0, 0, drop);
    if (d == 0) drop_a = drop;
    else        drop_b = drop;
  endtask

  task automatic build(int macsel, bit etype_bad, int ihl, bit ver_bad, bit csum_bad, bit proto_bad,
                       bit dip_bad, int dport, int ulen, int plen, bit seq);
    u8 h[$];
    logic [47:0] dm;
    logic [31:0] s, c, dipv;
    int hl;
    hl = ihl * 4;
    fr.delete();
    dm = (macsel == 0) ? MAC : (macsel == 1) ? 48'hFFFF_FFFF_FFFF : (MAC ^ 48'h0000_0100_0000);
    for (int i = 5; i >= 0; i--) fr.push_back(dm[8*i +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back((i == 0) ? 8'h02 : 8'(i));
    fr.push_back(8'h08);
    fr.push_back(etype_bad ? 8'h06 : 8'h00);
    for (int i = 0; i < hl; i++) h.push_back(8'h00);
    h[0] = {ver_bad ? 4'h6 : 4'h4, 4'(ihl)};
    h[2] = 8'((hl + ulen) >> 8);
    h[3] = 8'(hl + ulen);
    h[4] = 8'($urandom);
    h[8] = 8'd64;
    h[9] = proto_bad ? 8'd6 : 8'd17;
    h[12] = 8'hC0; h[13] = 8'h00; h[14] = 8'h02; h[15] = 8'h01;
    dipv = dip_bad ? (IP ^ 32'h1) : IP;
    for (int i = 0; i < 4; i++) h[16+i] = dipv[31-8*i -: 8];
    for (int i = 20; i < hl; i++) h[i] = 8'($urandom);
    s = 0;
    for (int i = 0; i < hl; i += 2) s += {16'h0, h[i], h[i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    h[10] = ~s[15:8];
    h[11] = ~s[7:0];
    if (csum_bad) h[(ihl > 5) ? 20 : 4] ^= 8'h10;
    foreach (h[i]) fr.push_back(h[i]);
    fr.push_back(8'h04); fr.push_back(8'hD2);
    fr.push_back(8'(dport >> 8)); fr.push_back(8'(dport));
    fr.push_back(8'(ulen >> 8));  fr.push_back(8'(ulen));
    fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 0; i < plen; i++) fr.push_back(seq ? 8'(i) : 8'($urandom));
    while (fr.size() < 60) fr.push_back(8'h00);
    c = '1;
    foreach (fr[i]) begin
      c ^= {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    if (fcs_bad) fr[fr.size()-4] ^= 8'h01;
  endtask

  task automatic send_byte(u8 b, bit eof);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk); #1;
    received_byte = b;
    byte_valid = 1'b1;
    if (eof) rx_active = 1'b0;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic preamble();
    rx_active = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
  endtask

  task automatic post_checks();
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    check("a_drop_count", a_dc, drop_a);
    check("b_drop_count", b_dc, drop_b);
  endtask

  task automatic run(int n, bit same);
    model(0, n, 1'b0);
    model(1, n, 1'b0);
    preamble();
    for (int i = 0; i < n; i++) send_byte(fr[i], same && (i == n - 1));
    if (!same) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      @(posedge clk); #1;
      rx_active = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    post_checks();
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_a_payload"}, a_payload, 0); check({tag, "_a_pv"}, a_pv, 0);
    check({tag, "_a_pl"}, a_pl, 0);           check({tag, "_a_pa"}, a_pa, 0);
    check({tag, "_a_pc"}, a_pc, 0);           check({tag, "_a_fg"}, a_fg, 0);
    check({tag, "_a_fb"}, a_fb, 0);           check({tag, "_a_dc"}, a_dc, 0);
    check({tag, "_b_pv"}, b_pv, 0);           check({tag, "_b_dc"}, b_dc, 0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, r, plen, ulen, dport;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("post_reset");

    build(0, 0, 5, 0, 0, 0, 0, 5006, 18, 10, 1); run(fr.size(), 0);
    build(0, 0, 6, 0, 0, 0, 0, 5006, 18, 10, 1); run(fr.size(), 1);
    build(0, 0, 6, 0, 1, 0, 0, 5006, 18, 10, 1); run(fr.size(), 0);
    build(1, 0, 5, 0, 0, 0, 0, 5005, 18, 10, 1); run(fr.size(), 0);
    build(0, 0, 5, 0, 0, 0, 0, 6000, 18, 10, 1); run(fr.size(), 0);
    build(0, 0, 5, 0, 0, 1, 0, 5006, 18, 10, 1); run(fr.size(), 0);
    build(0, 0, 5, 0, 0, 0, 0, 5006, 18, 10, 1); run(14 + 20 + 8 + 4, 0);
    build(0, 0, 5, 0, 0, 0, 0, 5008, 18, 10, 1); run(fr.size(), 0);
    build(0, 0, 5, 0, 0, 0, 0, 5007, 8, 0, 1);   run(fr.size(), 0);
    build(0, 0, 5, 0, 0, 0, 0, 5007, 4, 0, 1);   run(fr.size(), 0);
    fcs_bad = 1'b1;
    build(0, 0, 5, 0, 0, 0, 0, 5006, 18, 10, 1); run(fr.size(), 0);
    fcs_bad = 1'b0;

    // Reset mid-payload: the fifth payload byte is on the outputs when resetn drops.
    build(0, 0, 5, 0, 0, 0, 0, 5006, 18, 10, 1);
    k = 14 + 20 + 8 + 5;
    model(0, k - 1, 1'b1);
    model(1, k - 1, 1'b1);
    preamble();
    for (int i = 0; i < k; i++) send_byte(fr[i], 1'b0);
    check("pre_reset_valid", a_pv, 1);
    #1 resetn = 1'b0;
    #1 chk_zero("mid_reset");
    rx_active = 1'b0;
    drop_a = 0; drop_b = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    post_checks();
    build(0, 0, 5, 0, 0, 0, 0, 5005, 18, 10, 1); run(fr.size(), 0);

    for (int f = 0; f < 50; f++) begin
      r = $urandom_range(0, 99);
      dport = ($urandom_range(0, 99) < 85) ? 5005 + $urandom_range(0, 3) : 6000;
      plen = $urandom_range(0, 40);
      ulen = ($urandom_range(0, 19) == 0) ? 4 : plen + 8;
      fcs_bad = ($urandom_range(0, 9) == 0);
      build((r < 70) ? 0 : (r < 85) ? 1 : 2, ($urandom_range(0, 19) == 0),
            $urandom_range(5, 8), ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0), dport, ulen, plen, 1'b0);
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, fr.size() - 1) : fr.size();
      run(n, 1'($urandom_range(0, 1)));
    end
    fcs_bad = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
